data_memory_dump_ctrl: RTL and testbench

Arbiter and sequencer for the MIPS data memory port. In normal operation it passes the MEM-stage access straight to data memory. On a dump request from the debug unit it stalls the pipeline, takes the port, and reads every word in ascending address order. Each word is streamed as bytes over a valid/ready handshake to the UART transmit path.

---
 rtl/data_memory_dump_ctrl.sv | 135 +++++++++++++
 tb/tb_data_memory_dump_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_dump_ctrl.sv
// Data memory port arbiter: passes MEM-stage accesses through in IDLE and, on a
// dump request, stalls the CPU and streams every memory word out as bytes, MSB first.
module data_memory_dump_ctrl #(
  parameter int NB_ADDR      = 5,
  parameter int NB_DATA      = 32,
  parameter int MEMORY_DEPTH = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cpu_mem_write,
  input  logic               i_cpu_mem_read,
  input  logic [NB_ADDR-1:0] i_cpu_address,
  input  logic [NB_DATA-1:0] i_cpu_write_data,
  input  logic [NB_DATA-1:0] i_mem_read_data,
  output logic               o_mem_enable,
  output logic               o_mem_write,
  output logic               o_mem_read,
  output logic [NB_ADDR-1:0] o_mem_address,
  output logic [NB_DATA-1:0] o_mem_write_data,
  input  logic               i_dump_start,
  output logic               o_dump_busy,
  output logic               o_dump_done,
  output logic               o_cpu_stall,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);

  logic [2:0]         state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_DATA-1:0] word_q, word_d;
  logic [NB_IDX-1:0]  idx_q, idx_d;
  logic [7:0]         tx_byte;

  // Handshake: a byte moves when o_tx_valid & i_tx_ready in the same cycle.
  // o_tx_valid depends only on state, and data is held until the byte is taken.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (i_dump_start) begin
          state_d = ST_READ;
          addr_d  = '0;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        word_d  = i_mem_read_data;
        idx_d   = NB_IDX'(NB_BYTES - 1);
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          if (idx_q != '0) begin
            idx_d = idx_q - NB_IDX'(1);
          end else if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + NB_ADDR'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    tx_byte = '0;
    for (int b = 0; b < NB_BYTES; b++) begin
      if (idx_q == NB_IDX'(b)) tx_byte = word_q[b*8 +: 8];
    end
  end

  // The memory port is forced quiet while reset is held, whatever the state.
  always_comb begin
    o_mem_enable     = 1'b0;
    o_mem_write      = 1'b0;
    o_mem_read       = 1'b0;
    o_mem_address    = addr_q;
    o_mem_write_data = '0;
    if (i_reset) begin
      case (state_q)
        ST_IDLE: begin
          o_mem_enable     = 1'b1;
          o_mem_write      = i_cpu_mem_write;
          o_mem_read       = i_cpu_mem_read;
          o_mem_address    = i_cpu_address;
          o_mem_write_data = i_cpu_write_data;
        end
        ST_READ, ST_WAIT: begin
          o_mem_enable = 1'b1;
          o_mem_read   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_tx_valid  = (state_q == ST_SEND);
  assign o_tx_data   = (state_q == ST_SEND) ? tx_byte : 8'h00;
  assign o_dump_done = (state_q == ST_DONE);
  assign o_dump_busy = (state_q != ST_IDLE);
  assign o_cpu_stall = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_memory_dump_ctrl.sv
// Bench for data_memory_dump_ctrl: pass-through vector table, then dump
// sequences (free-running, backpressure, CPU write, restart, mid-dump reset).
module tb_data_memory_dump_ctrl;

  localparam int NB_ADDR = 5;
  localparam int NB_DATA = 32;
  localparam int DEPTH   = 32;

  logic               clk = 1'b0;
  logic               i_reset;
  logic               i_cpu_mem_write, i_cpu_mem_read;
  logic [NB_ADDR-1:0] i_cpu_address;
  logic [NB_DATA-1:0] i_cpu_write_data;
  logic [NB_DATA-1:0] rd_q;
  logic               o_mem_enable, o_mem_write, o_mem_read;
  logic [NB_ADDR-1:0] o_mem_address;
  logic [NB_DATA-1:0] o_mem_write_data;
  logic               i_dump_start, o_dump_busy, o_dump_done, o_cpu_stall;
  logic [7:0]         o_tx_data;
  logic               o_tx_valid, i_tx_ready;

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [7:0]         exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  data_memory_dump_ctrl #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .MEMORY_DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_cpu_mem_write(i_cpu_mem_write), .i_cpu_mem_read(i_cpu_mem_read),
    .i_cpu_address(i_cpu_address), .i_cpu_write_data(i_cpu_write_data),
    .i_mem_read_data(rd_q),
    .o_mem_enable(o_mem_enable), .o_mem_write(o_mem_write), .o_mem_read(o_mem_read),
    .o_mem_address(o_mem_address), .o_mem_write_data(o_mem_write_data),
    .i_dump_start(i_dump_start), .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done),
    .o_cpu_stall(o_cpu_stall), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready)
  );

  // clock / memory model with a registered read port
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_mem_enable) begin
      if (o_mem_write) mem[o_mem_address] <= o_mem_write_data;
      if (o_mem_read)  rd_q <= mem[o_mem_address];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_idle();
    i_cpu_mem_write  = 1'b0;
    i_cpu_mem_read   = 1'b0;
    i_cpu_address    = '0;
    i_cpu_write_data = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, o_tx_valid, 0);
    check({tag, "_tx_data"},  o_tx_data, 0);
    check({tag, "_busy"},     o_dump_busy, 0);
    check({tag, "_done"},     o_dump_done, 0);
    check({tag, "_stall"},    o_cpu_stall, 0);
  endtask

  // Runs one dump from an IDLE cycle and scores the byte stream.
  task automatic run_dump(input int ready_pct, input bit cpu_wr_mode, input int restart_at);
    int c = 1;
    int done_cnt = 0, done_cyc = -1, idle_cyc = -1;
    int stall_cnt = 0, hold_err = 0, wr_err = 0, nbytes = 0;
    bit prev_pend = 1'b0, finished = 1'b0, wr_active = cpu_wr_mode;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_b;
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'(k));
    end
    cpu_idle();
    step();
    i_dump_start = 1'b1;
    step();
    i_dump_start = 1'b0;
    while (!finished && c < 3000) begin
      i_tx_ready   = ($urandom_range(99) < ready_pct);
      i_dump_start = (c == restart_at);
      if (wr_active) begin
        i_cpu_mem_write  = 1'b1;
        i_cpu_address    = 5'd5;
        i_cpu_write_data = 32'hFFFF_FFFF;
      end else cpu_idle();
      #1;
      if (c == 1) begin
        check("busy_at_cycle1", o_dump_busy, 1);
        check("stall_at_cycle1", o_cpu_stall, 1);
      end
      if (o_cpu_stall) stall_cnt++;
      if (o_dump_busy && o_mem_write) wr_err++;
      if (prev_pend && (!o_tx_valid || o_tx_data !== prev_data)) hold_err++;
      if (o_tx_valid && i_tx_ready) begin
        nbytes++;
        if (exp_q.size() == 0) check("extra_byte", 1, 0);
        else begin
          exp_b = exp_q.pop_front();
          check("dump_byte", o_tx_data, exp_b);
        end
      end
      prev_pend = o_tx_valid && !i_tx_ready;
      prev_data = o_tx_data;
      if (o_dump_done) begin
        done_cnt++;
        done_cyc = c;
        check("stall_in_done", o_cpu_stall, 1);
        wr_active = 1'b0;
        cpu_idle();
      end
      if (!o_dump_busy) begin
        finished = 1'b1;
        idle_cyc = c;
      end else begin
        step();
        c++;
      end
    end
    i_tx_ready   = 1'b0;
    i_dump_start = 1'b0;
    check("dump_finished", finished, 1);
    check("done_pulses", done_cnt, 1);
    check("byte_count", nbytes, DEPTH * 4);
    check("bytes_left", exp_q.size(), 0);
    check("hold_violations", hold_err, 0);
    check("mem_write_in_dump", wr_err, 0);
    if (ready_pct >= 100) begin
      check("done_cycle", done_cyc, 193);
      check("idle_cycle", idle_cyc, 194);
      check("stall_cycles", stall_cnt, 193);
    end
  endtask

  typedef struct {
    logic               wr;
    logic               rd;
    logic [NB_ADDR-1:0] addr;
    logic [NB_DATA-1:0] wdata;
    logic               chk_rd;
    logic [NB_DATA-1:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 5'd3, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 5'd3, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 5'd7, 32'h1234_5678, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 5'd7, 32'hAAAA_5555, 1'b1, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b1, 5'd3, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b0, 5'd9, 32'h0BAD_F00D, 1'b0, 32'h0};

    // reset
    i_reset = 1'b0;
    i_dump_start = 1'b0;
    i_tx_ready = 1'b0;
    cpu_idle();
    i_cpu_mem_write = 1'b1;
    i_cpu_mem_read  = 1'b1;
    step();
    step();
    check("rst_mem_enable", o_mem_enable, 0);
    check("rst_mem_write", o_mem_write, 0);
    check("rst_mem_read", o_mem_read, 0);
    check_reset_outputs("rst");
    cpu_idle();
    i_reset = 1'b1;
    step();

    // pass-through table
    foreach (vecs[i]) begin
      i_cpu_mem_write  = vecs[i].wr;
      i_cpu_mem_read   = vecs[i].rd;
      i_cpu_address    = vecs[i].addr;
      i_cpu_write_data = vecs[i].wdata;
      #1;
      check("pt_enable", o_mem_enable, 1);
      check("pt_write", o_mem_write, vecs[i].wr);
      check("pt_read", o_mem_read, vecs[i].rd);
      check("pt_address", o_mem_address, vecs[i].addr);
      check("pt_wdata", o_mem_write_data, vecs[i].wdata);
      check("pt_stall", o_cpu_stall, 0);
      step();
      if (vecs[i].chk_rd) check("pt_read_data", rd_q, vecs[i].exp_rd);
    end

    // preload through the pass-through path
    for (int k = 0; k < DEPTH; k++) begin
      i_cpu_mem_write  = 1'b1;
      i_cpu_mem_read   = 1'b0;
      i_cpu_address    = NB_ADDR'(k);
      i_cpu_write_data = 32'h0102_0300 + 32'(k);
      step();
    end
    cpu_idle();

    run_dump(100, 1'b0, -1);
    run_dump(30, 1'b0, -1);
    run_dump(100, 1'b1, -1);
    run_dump(100, 1'b0, 50);

    // reset in the middle of a dump
    step();
    i_dump_start = 1'b1;
    step();
    i_dump_start = 1'b0;
    i_tx_ready = 1'b1;
    for (int c = 1; c < 40; c++) begin
      #1;
      if (o_dump_done) check("midrst_early_done", 1, 0);
      step();
    end
    i_reset = 1'b0;
    step();
    check_reset_outputs("midrst");
    check("midrst_mem_enable", o_mem_enable, 0);
    i_reset = 1'b1;
    i_tx_ready = 1'b0;
    #1;
    check("midrst_release_stall", o_cpu_stall, 0);
    check("midrst_release_enable", o_mem_enable, 1);
    run_dump(100, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
